// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// response status codes and frame/response widths.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    WHI    = 3'd2,
    WLO    = 3'd3,
    CHK    = 3'd4,
    START  = 3'd5,
    RUN    = 3'd6,
    RESP   = 3'd7
  } loader_state_t;

  localparam logic [7:0] ST_OK  = 8'h00;
  localparam logic [7:0] ST_LEN = 8'h01;
  localparam logic [7:0] ST_CHK = 8'h02;
  localparam logic [7:0] ST_TMO = 8'h03;

  localparam int ADDR_W = 10;
  localparam int WORD_W = 16;
  localparam int RESP_W = 24;

  // Response frame as sent on the wire: status first, then result hi, result lo.
  function automatic logic [RESP_W-1:0] pack_resp(input logic [7:0] status,
                                                  input logic [WORD_W-1:0] result);
    return {status, result};
  endfunction

endpackage

// File: rtl/prog_loader_resp_tx.sv
// resp_tx: serialises a 24-bit {status, result} response into three bytes,
// MSB first, over a valid/ready byte port; o_done marks the final accept.
module resp_tx
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_load,
  input  logic [RESP_W-1:0] i_payload,
  input  logic              i_tx_ready,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_done
);

  logic        r_valid;
  logic [7:0]  r_data;
  logic [15:0] r_shift;
  logic [1:0]  r_left;
  logic        w_fire;

  // A byte moves when valid and ready are both high on a rising edge;
  // data and valid hold unchanged while ready is low.
  assign w_fire     = r_valid & i_tx_ready;
  assign o_tx_valid = r_valid;
  assign o_tx_data  = r_data;
  assign o_done     = w_fire & (r_left == 2'd0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_valid <= 1'b0;
      r_data  <= 8'h00;
      r_shift <= 16'h0000;
      r_left  <= 2'd0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_payload[23:16];
      r_shift <= i_payload[15:0];
      r_left  <= 2'd2;
    end else if (w_fire) begin
      if (r_left == 2'd0) begin
        r_valid <= 1'b0;
      end else begin
        r_data  <= r_shift[15:8];
        r_shift <= {r_shift[7:0], 8'h00};
        r_left  <= r_left - 2'd1;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed program frame, writes it to the core's
// code RAM, starts the core, and returns a 3-byte status/result response.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [ADDR_W-1:0]  cpu_addr,
  output logic               cpu_wr,
  output logic [WORD_W-1:0]  cpu_datain,
  output logic               cpu_start,
  input  logic               cpu_ready,
  input  logic [WORD_W-1:0]  cpu_out,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT);
`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t AFTER_DATA = CHK;
`else
  localparam loader_state_t AFTER_DATA = START;
`endif

  loader_state_t r_state;
  loader_state_t w_state_nxt;

  logic [15:0]       r_len;
  logic [15:0]       r_idx;
  logic [7:0]        r_hi;
  logic              r_cpu_wr;
  logic [ADDR_W-1:0] r_cpu_addr;
  logic [WORD_W-1:0] r_cpu_datain;
  logic              r_cpu_start;
  logic [TW-1:0]     r_cnt;
  logic [7:0]        r_status;
  logic [WORD_W-1:0] r_result;
  logic              r_resp_load;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_chk;
`endif

  logic              w_rx_fire;
  logic [15:0]       w_len_full;
  logic              w_len_over;
  logic              w_last_word;
  logic              w_wr_en;
  logic              w_start_en;
  logic              w_resp_load;
  logic [7:0]        w_status_nxt;
  logic [WORD_W-1:0] w_result_nxt;
  logic              w_tx_done;
  logic [RESP_W-1:0] w_payload;

  // Inbound bytes use valid/ready: a byte is consumed on a rising edge where
  // rx_valid and rx_ready are both high; rx_ready depends only on state.
  assign rx_ready    = r_state inside {IDLE, LEN_LO, WHI, WLO, CHK};
  assign w_rx_fire   = rx_valid & rx_ready;
  assign w_len_full  = {r_len[15:8], rx_data};
  assign w_len_over  = 32'(w_len_full) > 32'(DEPTH);
  assign w_last_word = (r_idx == (r_len - 16'd1));
  assign w_payload   = pack_resp(r_status, r_result);

  assign cpu_wr     = r_cpu_wr;
  assign cpu_addr   = r_cpu_addr;
  assign cpu_datain = r_cpu_datain;
  assign cpu_start  = r_cpu_start;
  assign busy       = (r_state != IDLE);
  assign dbg_state  = r_state;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_en      = 1'b0;
    w_start_en   = 1'b0;
    w_resp_load  = 1'b0;
    w_status_nxt = ST_OK;
    w_result_nxt = '0;
    case (r_state)
      IDLE: begin
        if (w_rx_fire) w_state_nxt = LEN_LO;
      end
      LEN_LO: begin
        if (w_rx_fire) begin
          if (w_len_full == 16'h0000) begin
            w_state_nxt = AFTER_DATA;
          end else if (w_len_over) begin
            w_resp_load  = 1'b1;
            w_status_nxt = ST_LEN;
            w_state_nxt  = RESP;
          end else begin
            w_state_nxt = WHI;
          end
        end
      end
      WHI: begin
        if (w_rx_fire) w_state_nxt = WLO;
      end
      WLO: begin
        if (w_rx_fire) begin
          w_wr_en     = 1'b1;
          w_state_nxt = w_last_word ? AFTER_DATA : WHI;
        end
      end
      CHK: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_rx_fire) begin
          if (rx_data == r_chk) begin
            w_state_nxt = START;
          end else begin
            w_resp_load  = 1'b1;
            w_status_nxt = ST_CHK;
            w_state_nxt  = RESP;
          end
        end
`else
        w_state_nxt = IDLE;
`endif
      end
      START: begin
        // Entered on the edge that registers the final write, so the start
        // pulse always lands at least one cycle after cpu_wr.
        if (cpu_ready && !r_cpu_wr) begin
          w_start_en  = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // The core only drops ready after it has seen the start pulse, so
        // ready is ignored during the pulse cycle itself.
        if (!r_cpu_start && cpu_ready) begin
          w_resp_load  = 1'b1;
          w_status_nxt = ST_OK;
          w_result_nxt = cpu_out;
          w_state_nxt  = RESP;
        end else if (r_cnt == TMO_LAST) begin
          w_resp_load  = 1'b1;
          w_status_nxt = ST_TMO;
          w_state_nxt  = RESP;
        end
      end
      RESP: begin
        if (w_tx_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_len        <= 16'h0000;
      r_idx        <= 16'h0000;
      r_hi         <= 8'h00;
      r_cpu_wr     <= 1'b0;
      r_cpu_addr   <= '0;
      r_cpu_datain <= '0;
      r_cpu_start  <= 1'b0;
      r_cnt        <= '0;
      r_status     <= ST_OK;
      r_result     <= '0;
      r_resp_load  <= 1'b0;
    end else begin
      r_cpu_wr    <= w_wr_en;
      r_cpu_start <= w_start_en;
      r_resp_load <= w_resp_load;
      if (r_state == IDLE && w_rx_fire) r_len[15:8] <= rx_data;
      if (r_state == LEN_LO && w_rx_fire) begin
        r_len <= w_len_full;
        r_idx <= 16'h0000;
      end
      if (r_state == WHI && w_rx_fire) r_hi <= rx_data;
      if (w_wr_en) begin
        r_cpu_addr   <= r_idx[ADDR_W-1:0];
        r_cpu_datain <= {r_hi, rx_data};
        r_idx        <= r_idx + 16'd1;
      end
      if (w_start_en)          r_cnt <= '0;
      else if (r_state == RUN) r_cnt <= r_cnt + TW'(1);
      if (w_resp_load) begin
        r_status <= w_status_nxt;
        r_result <= w_result_nxt;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR over every frame byte from LEN_HI onwards.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                           r_chk <= 8'h00;
    else if (r_state == IDLE && w_rx_fire) r_chk <= rx_data;
    else if (w_rx_fire)                  r_chk <= r_chk ^ rx_data;
  end
`endif

  resp_tx u_resp_tx (
    .clk        (clk),
    .nrst       (nrst),
    .i_load     (r_resp_load),
    .i_payload  (w_payload),
    .i_tx_ready (tx_ready),
    .o_tx_valid (tx_valid),
    .o_tx_data  (tx_data),
    .o_done     (w_tx_done)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: randomized frames against a reference program model,
// with a small behavioural stack-core attached to the cpu_* port.
module tb_prog_loader;

  localparam int DEPTH   = 1024;
  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        nrst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [9:0]  cpu_addr;
  logic        cpu_wr;
  logic [15:0] cpu_datain;
  logic        cpu_start;
  logic        cpu_ready;
  logic [15:0] cpu_out;
  logic        busy;
  logic [2:0]  dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  prog_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .cpu_addr   (cpu_addr),
    .cpu_wr     (cpu_wr),
    .cpu_datain (cpu_datain),
    .cpu_start  (cpu_start),
    .cpu_ready  (cpu_ready),
    .cpu_out    (cpu_out),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_starts = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard
  logic [25:0] exp_wr_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [15:0] ref_mem [DEPTH];
  logic [15:0] core_mem[DEPTH];

  // Program semantics: 00/01 = push word, 10 = spin forever, 11 = halt.
  // Result is the last pushed word (0 if none).
  function automatic void exec_prog(input bit on_core, output bit looped,
                                    output logic [15:0] res, output int steps);
    logic [15:0] w;
    res = 16'h0000; looped = 1'b0; steps = 0;
    for (int pc = 0; pc < DEPTH; pc++) begin
      w = on_core ? core_mem[pc] : ref_mem[pc];
      steps++;
      if (w[15:14] == 2'b11) return;
      if (w[15:14] == 2'b10) begin looped = 1'b1; return; end
      res = w;
    end
    looped = 1'b1;
  endfunction

  // behavioural core
  logic        core_ready;
  logic [15:0] core_out;
  logic [15:0] core_pend;
  int          core_left;
  assign cpu_ready = core_ready;
  assign cpu_out   = core_out;

  always @(posedge clk or negedge nrst) begin
    bit          lp;
    logic [15:0] r;
    int          st;
    if (!nrst) begin
      core_ready <= 1'b1;
      core_out   <= 16'h0000;
      core_pend  <= 16'h0000;
      core_left  <= 0;
    end else begin
      if (cpu_wr) core_mem[cpu_addr] <= cpu_datain;
      if (cpu_start && core_ready) begin
        exec_prog(1'b1, lp, r, st);
        core_ready <= 1'b0;
        core_left  <= lp ? 40 : st + 1;
        core_pend  <= lp ? 16'hDEAD : r;
      end else if (!core_ready) begin
        if (core_left <= 1) begin
          core_ready <= 1'b1;
          core_out   <= core_pend;
        end else begin
          core_left <= core_left - 1;
        end
      end
    end
  end

  // sink-side ready driver
  bit hold_tx = 1'b0;
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_ready = hold_tx ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // monitor
  logic [25:0] mon_e;
  logic [7:0]  mon_b;
  bit          prev_hold = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  bit          tx_drop_pend = 1'b0;

  always @(negedge clk) begin
    if (nrst) begin
      if (cpu_wr) begin
        if (exp_wr_q.size() == 0) check("wr_extra", 32'd1, 32'd0);
        else begin
          mon_e = exp_wr_q.pop_front();
          check("wr", {6'd0, cpu_addr, cpu_datain}, {6'd0, mon_e});
        end
      end
      if (cpu_start) begin
        n_starts++;
        check("start_rdy", {31'd0, cpu_ready}, 32'd1);
        check("start_nowr", {31'd0, cpu_wr}, 32'd0);
      end
      if (tx_drop_pend) begin
        check("tx_drop", {31'd0, tx_valid}, 32'd0);
        tx_drop_pend = 1'b0;
      end
      if (prev_hold) begin
        check("hold_v", {31'd0, tx_valid}, 32'd1);
        check("hold_d", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx_q.size() == 0) check("tx_extra", 32'd1, 32'd0);
        else begin
          mon_b = exp_tx_q.pop_front();
          check("tx", {24'd0, tx_data}, {24'd0, mon_b});
          if (exp_tx_q.size() == 0) tx_drop_pend = 1'b1;
        end
      end
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
    end else begin
      prev_hold    = 1'b0;
      tx_drop_pend = 1'b0;
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int budget;
    budget = 300;
    rx_data  = b;
    rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      budget--;
      if (budget == 0) begin
        check("rx_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 600; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (k == 600) check("idle_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input logic [15:0] len, input logic [15:0] words[$], input bit bad_chk);
    logic [7:0]  chk;
    logic [7:0]  st;
    logic [15:0] res;
    logic [9:0]  a;
    bit          lp;
    int          steps;
    int          s0;
    int          exp_start;
    s0 = n_starts;
    exp_start = 0;
    res = 16'h0000;
    if (int'(len) > DEPTH) begin
      st = 8'h01;
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        a = 10'(i);
        ref_mem[i] = words[i];
        exp_wr_q.push_back({a, words[i]});
      end
      if (bad_chk) begin
        st = 8'h02;
      end else begin
        exp_start = 1;
        exec_prog(1'b0, lp, res, steps);
        if (lp) begin st = 8'h03; res = 16'h0000; end
        else st = 8'h00;
      end
    end
    exp_tx_q.push_back(st);
    exp_tx_q.push_back(res[15:8]);
    exp_tx_q.push_back(res[7:0]);

    chk = len[15:8] ^ len[7:0];
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    if (int'(len) <= DEPTH) begin
      for (int i = 0; i < int'(len); i++) begin
        chk = chk ^ words[i][15:8] ^ words[i][7:0];
        send_byte(words[i][15:8]);
        send_byte(words[i][7:0]);
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(bad_chk ? ~chk : chk);
`endif
    end
    wait_idle();
    check("tx_left", exp_tx_q.size(), 32'd0);
    check("wr_left", exp_wr_q.size(), 32'd0);
    check("starts", n_starts - s0, exp_start);
  endtask

  function automatic logic [15:0] rand_push();
    return 16'($urandom_range(0, 16'h7FFF));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [15:0] q[$];
    logic [15:0] w0, w1;
    int          n;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
    nrst = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk); #1;
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_cpu_wr", {31'd0, cpu_wr}, 32'd0);
    check("rst_cpu_start", {31'd0, cpu_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    nrst = 1'b1;
    @(posedge clk); #1;

    // basic two-word program
    q = '{16'h0005, 16'hC000};
    run_frame(16'd2, q, 1'b0);
    // empty frame reruns the resident program
    q.delete();
    run_frame(16'd0, q, 1'b0);
    // oversize length rejected, then a normal frame
    run_frame(16'h0401, q, 1'b0);
    q = '{16'h1234, 16'h0042, 16'hC123};
    run_frame(16'd3, q, 1'b0);

    // sink stalls for 10 cycles mid-response
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          @(negedge clk);
          if (tx_valid) break;
        end
        hold_tx = 1'b1;
        repeat (10) @(posedge clk);
        hold_tx = 1'b0;
      end
    join_none
    q = '{16'h2A2A, 16'hC000};
    run_frame(16'd2, q, 1'b0);

    // run timeout, then a frame whose start must wait for the busy core
    q = '{16'h8000};
    run_frame(16'd1, q, 1'b0);
    q = '{16'h0007, 16'hC000};
    run_frame(16'd2, q, 1'b0);

    // largest accepted length fills the whole RAM
    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(i == 1 ? 16'hC000 : rand_push());
    run_frame(16'(DEPTH), q, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    q = '{16'h0099, 16'hC000};
    run_frame(16'd2, q, 1'b1);
`endif

    // reset in WLO of the third word
    w0 = rand_push();
    w1 = rand_push() | 16'h0101;
    ref_mem[0] = w0;
    ref_mem[1] = w1;
    exp_wr_q.push_back({10'd0, w0});
    exp_wr_q.push_back({10'd1, w1});
    send_byte(8'h00); send_byte(8'h03);
    send_byte(w0[15:8]); send_byte(w0[7:0]);
    send_byte(w1[15:8]); send_byte(w1[7:0]);
    send_byte(8'h11);
    repeat (2) begin @(posedge clk); #1; end
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    nrst = 1'b0;
    #1;
    check("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("mid_rst_cpu_wr", {31'd0, cpu_wr}, 32'd0);
    check("mid_rst_cpu_start", {31'd0, cpu_start}, 32'd0);
    check("mid_rst_cpu_addr", {22'd0, cpu_addr}, 32'd0);
    check("mid_rst_cpu_datain", {16'd0, cpu_datain}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_wr_left", exp_wr_q.size(), 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;

    // randomized frames
    for (int f = 0; f < 25; f++) begin
      q.delete();
      if (f % 7 == 6) begin
        run_frame(16'($urandom_range(DEPTH + 1, 16'hFFFF)), q, 1'b0);
      end else begin
        n = $urandom_range(1, 8);
        for (int i = 0; i < n - 1; i++) q.push_back(rand_push());
        q.push_back(16'hC000 | 16'($urandom_range(0, 16'h3FFF)));
        run_frame(16'(n), q, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
